solution_framer: RTL and testbench
==================================

// Module: solution_framer
// PURPOSE
//  Transmit-side counterpart of the parser: serialises a solved (or unsolvable) board into a framed
//  byte stream for uart_tx. Sits between the solver outputs and the transmitter. Latches grid, dims
//  and status on a one-cycle valid_in pulse. Then issues one byte per send/transmit_done handshake:
//  sync, dims, status, packed rows, checksum.
// PARAMETERS
//  MAX_ROWS   11     max board rows; must be <= 15 (dims travel as nibbles)
//  MAX_COLS   11     max board cols; must be <= 15
//  SYNC_BYTE  8'hA5  first byte of every frame
// PORTS
//  clk            in   1                   system clock (50 MHz domain)
//  rst            in   1                   asynchronous, active-high reset
//  valid_in       in   1                   1-cycle pulse: board ready, sample inputs below
//  unsolvable     in   1                   sampled with valid_in; 1 = no solution
//  solution       in   MAX_ROWS*MAX_COLS   cell (r,c) at bit r*MAX_COLS+c; 1 = filled
//  m              in   $clog2(MAX_ROWS)    row count, sampled with valid_in
//  n              in   $clog2(MAX_COLS)    column count, sampled with valid_in
//  transmit_done  in   1                   uart_tx pulse: previous byte fully sent
//  send           out  1                   1-cycle pulse: byte_out valid, start transmission
//  byte_out       out  8                   byte to transmit; held stable until next send
//  busy           out  1                   high from valid_in acceptance until done
//  done           out  1                   1-cycle pulse after the checksum byte's transmit_done
// BEHAVIOUR
//  Reset: send=0, byte_out=0, busy=0, done=0, state IDLE, checksum=0. Async assert, sync release.
//  Frame: SYNC, DIM={m[3:0],n[3:0]}, STAT (8'h01 solved / 8'h02 unsolvable), ROWS, CSUM.
//  ROWS: solved only. Per row r=0..m-1, ceil(n/8) bytes; cells MSB-first (col 0 -> bit 7).
//   Unused low bits are 0. Unsolvable frame omits ROWS entirely (4 bytes total).
//  CSUM: XOR of every byte after SYNC (DIM, STAT, all ROWS); SYNC is excluded.
//  Clamping: m>MAX_ROWS -> MAX_ROWS, n>MAX_COLS -> MAX_COLS. Clamped value is used in both DIM and ROWS.
//  m==0 or n==0: ROWS omitted; DIM reports the values as given.
//  FSM states:
//   IDLE: valid_in -> latch inputs, busy=1, goto LOAD.
//   LOAD: drive byte_out, pulse send, XOR byte into checksum (not SYNC/CSUM), goto WAIT.
//   WAIT: on transmit_done -> advance field/row/byte index. Goto LOAD if bytes remain, else DONE.
//   DONE: pulse done, busy=0, goto IDLE.
//  Latency: valid_in at cycle t -> first send at t+1; transmit_done at k -> next send at k+1.
//   done is asserted at k+1 after the CSUM byte's transmit_done at k.
//  Counters: row index 0..MAX_ROWS-1, byte-in-row index 0..ceil(MAX_COLS/8)-1. Both reset per frame.
//  valid_in while busy: ignored; latched board unchanged.
//  transmit_done outside WAIT: ignored.
//  transmit_done in the same cycle as send: ignored (byte not yet started).
//  Inputs other than transmit_done are don't-care after latching.
//  Reset mid-frame: immediate return to reset values; no further send; partial frame abandoned.
//  valid_in in the same cycle as done: ignored; the next frame requires a new pulse in IDLE.
// TESTING
//  T1 m=2,n=2, rows 10/01, solved -> bytes A5 22 01 80 40 E3; done 1 cycle after 6th transmit_done.
//  T2 m=11,n=11 all cells 1 -> 26 bytes: A5 BB 01, then (FF E0)x11, then CSUM A5.
//  T3 m=5,n=5 unsolvable -> A5 55 02 57 only; busy low after done.
//  T4 m=1,n=8 all 1 -> A5 18 01 FF E6. Hold transmit_done low 1000 cycles: no extra send, byte_out stable.
//  T5 assert rst during the 3rd byte of T2 -> send/busy/done = 0 immediately, no further sends.
//   New valid_in afterwards -> clean T1 frame.
//  T6 second valid_in (different grid) mid-T1, plus spurious transmit_done in IDLE -> T1 bytes unchanged.

Source files
------------

// File: rtl/solution_framer.sv
// Serialises a latched board into a framed byte stream for uart_tx:
// SYNC, DIM, STAT, packed rows (solved only), XOR checksum of everything after SYNC.
module solution_framer #(
   parameter int          MAX_ROWS  = 11,
   parameter int          MAX_COLS  = 11,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_in,
   input  logic                         unsolvable,
   input  logic [MAX_ROWS*MAX_COLS-1:0] solution,
   input  logic [$clog2(MAX_ROWS)-1:0]  m,
   input  logic [$clog2(MAX_COLS)-1:0]  n,
   input  logic                         transmit_done,
   output logic                         send,
   output logic [7:0]                   byte_out,
   output logic                         busy,
   output logic                         done
);

   localparam int MW = $clog2(MAX_ROWS);
   localparam int NW = $clog2(MAX_COLS);
   localparam int NB = (MAX_COLS + 7) / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int PW = NB * 8;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;
   typedef enum logic [2:0] {F_SYNC, F_DIM, F_STAT, F_ROWS, F_CSUM} field_t;

   state_t               state_q;
   field_t               fld_q, fld_d;
   logic [MW-1:0]        r_q, r_d, m_q, lastr_q, m_c;
   logic [BW-1:0]        b_q, b_d, lastb_q;
   logic [NW-1:0]        n_q, n_c;
   logic                 unsolv_q, rows_en_q, last_d;
   logic [7:0]           csum_q, byte_d, row_byte, row_raw;
   logic [PW-1:0]        row_pad;
   logic                 send_q, busy_q, done_q;
   logic [7:0]           byte_out_q;
   logic [MAX_COLS-1:0]  grid_q   [MAX_ROWS];
   logic [MAX_COLS-1:0]  sol_rows [MAX_ROWS];

   for (genvar gr = 0; gr < MAX_ROWS; gr++) begin : g_rows
      assign sol_rows[gr] = solution[gr*MAX_COLS +: MAX_COLS];
   end

   // Oversized dims are clamped once at latch time so DIM and ROWS always agree.
   always_comb begin
      m_c = (32'(m) > MAX_ROWS) ? MW'(MAX_ROWS) : m;
      n_c = (32'(n) > MAX_COLS) ? NW'(MAX_COLS) : n;
   end

   // Next field/index after the current byte, and the byte that goes with it.
   always_comb begin
      fld_d  = fld_q;
      r_d    = r_q;
      b_d    = b_q;
      last_d = 1'b0;
      case (fld_q)
         F_SYNC: fld_d = F_DIM;
         F_DIM:  fld_d = F_STAT;
         F_STAT: begin
            fld_d = rows_en_q ? F_ROWS : F_CSUM;
            r_d   = '0;
            b_d   = '0;
         end
         F_ROWS: begin
            if (b_q != lastb_q) begin
               b_d = b_q + BW'(1);
            end else if (r_q != lastr_q) begin
               r_d = r_q + MW'(1);
               b_d = '0;
            end else begin
               fld_d = F_CSUM;
            end
         end
         default: last_d = 1'b1;
      endcase

      // Columns at or beyond n are masked; col 0 lands in bit 7.
      row_pad                 = '0;
      row_pad[MAX_COLS-1:0]   = grid_q[r_d];
      row_pad                 = row_pad & ~({PW{1'b1}} << n_q);
      row_raw                 = 8'(row_pad >> {b_d, 3'b000});
      row_byte                = {<<{row_raw}};

      case (fld_d)
         F_SYNC:  byte_d = SYNC_BYTE;
         F_DIM:   byte_d = {4'(m_q), 4'(n_q)};
         F_STAT:  byte_d = unsolv_q ? 8'h02 : 8'h01;
         F_ROWS:  byte_d = row_byte;
         F_CSUM:  byte_d = csum_q;
         default: byte_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fld_q      <= F_SYNC;
         r_q        <= '0;
         b_q        <= '0;
         m_q        <= '0;
         n_q        <= '0;
         lastr_q    <= '0;
         lastb_q    <= '0;
         unsolv_q   <= 1'b0;
         rows_en_q  <= 1'b0;
         grid_q     <= '{default: '0};
         csum_q     <= '0;
         send_q     <= 1'b0;
         byte_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         send_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (valid_in) begin
                  m_q        <= m_c;
                  n_q        <= n_c;
                  lastr_q    <= m_c - MW'(1);
                  lastb_q    <= BW'((n_c - NW'(1)) >> 3);
                  unsolv_q   <= unsolvable;
                  rows_en_q  <= !unsolvable && (m_c != '0) && (n_c != '0);
                  grid_q     <= sol_rows;
                  csum_q     <= '0;
                  fld_q      <= F_SYNC;
                  r_q        <= '0;
                  b_q        <= '0;
                  byte_out_q <= SYNC_BYTE;
                  send_q     <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_LOAD;
               end
            end
            // send is high in this cycle; a transmit_done here is not for this byte.
            S_LOAD: begin
               if (fld_q inside {F_DIM, F_STAT, F_ROWS})
                  csum_q <= csum_q ^ byte_out_q;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (transmit_done) begin
                  if (last_d) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     fld_q      <= fld_d;
                     r_q        <= r_d;
                     b_q        <= b_d;
                     byte_out_q <= byte_d;
                     send_q     <= 1'b1;
                     state_q    <= S_LOAD;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign send     = send_q;
   assign byte_out = byte_out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_solution_framer.sv
// Scoreboarded bench for solution_framer: directed frames, expected bytes queued up front,
// monitor checks every send/done against the queue and handshake latency.
module tb_solution_framer;

   localparam int MR = 11;
   localparam int MC = 11;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            valid_in = 1'b0;
   logic            unsolvable = 1'b0;
   logic [MR*MC-1:0] solution = '0;
   logic [3:0]      m = '0;
   logic [3:0]      n = '0;
   logic            transmit_done = 1'b0;
   logic            send, busy, done;
   logic [7:0]      byte_out;

   solution_framer #(.MAX_ROWS(MR), .MAX_COLS(MC), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .unsolvable(unsolvable),
      .solution(solution), .m(m), .n(n), .transmit_done(transmit_done),
      .send(send), .byte_out(byte_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int sends = 0;
   int trig_cyc = 0;
   int td_delay = 1;
   bit auto_en = 1'b1;

   // uart_tx stand-in: answers each send with transmit_done td_delay cycles later.
   initial begin
      forever begin
         @(posedge clk); #1;
         transmit_done = 1'b0;
         if (send && auto_en && !rst) begin
            repeat (td_delay) begin @(posedge clk); #1; end
            transmit_done = 1'b1;
            trig_cyc = cyc;
         end
      end
   end

   // Monitor: every send must match the queue head and follow its trigger by one cycle.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk); #1;
         if (send) begin
            sends++;
            total++;
            if (cyc != trig_cyc + 1) begin
               bad++;
               $display("FAIL send_latency got_cyc=%0d want_cyc=%0d", cyc, trig_cyc + 1);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_send got=%02h want=none", byte_out);
            end else begin
               e = exp_q.pop_front();
               if (byte_out !== e) begin
                  bad++;
                  $display("FAIL frame_byte got=%02h want=%02h", byte_out, e);
               end
            end
         end
         if (done) begin
            total++;
            if (cyc != trig_cyc + 1) begin
               bad++;
               $display("FAIL done_latency got_cyc=%0d want_cyc=%0d", cyc, trig_cyc + 1);
            end
            total++;
            if (exp_q.size() != 0) begin
               bad++;
               $display("FAIL frame_len left=%0d want=0", exp_q.size());
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic cycle();
      @(posedge clk); #2;
   endtask

   task automatic start_frame(input logic [3:0] mm, input logic [3:0] nn, input logic uns,
                              input logic [MR*MC-1:0] sol);
      cycle();
      m = mm; n = nn; unsolvable = uns; solution = sol; valid_in = 1'b1;
      trig_cyc = cyc;
      cycle();
      valid_in = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         cycle();
         if (done) begin ok = 1'b1; break; end
      end
      chk("done_seen", ok, 1);
      if (ok) chk("busy_at_done", busy, 0);
   endtask

   task automatic push_t1();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h22); exp_q.push_back(8'h01);
      exp_q.push_back(8'h80); exp_q.push_back(8'h40); exp_q.push_back(8'hE3);
   endtask

   task automatic push_t2();
      exp_q.push_back(8'hA5); exp_q.push_back(8'hBB); exp_q.push_back(8'h01);
      for (int i = 0; i < 11; i++) begin exp_q.push_back(8'hFF); exp_q.push_back(8'hE0); end
      exp_q.push_back(8'hA5);
   endtask

   logic [MR*MC-1:0] sol1, sol_all;
   int base, extra, unstable;
   bit hit;

   initial begin
      sol1 = '0; sol1[0] = 1'b1; sol1[12] = 1'b1;
      sol_all = '1;

      repeat (3) cycle();
      chk("rst_send", send, 0);
      chk("rst_byte", byte_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      repeat (2) cycle();

      // T1: small solved board
      td_delay = 1;
      push_t1();
      start_frame(4'd2, 4'd2, 1'b0, sol1);
      wait_done(200);

      // T2: full 11x11
      td_delay = 3;
      push_t2();
      start_frame(4'd11, 4'd11, 1'b0, sol_all);
      wait_done(500);

      // T3: unsolvable, plus a valid_in that lands while done is high
      td_delay = 2;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h55);
      exp_q.push_back(8'h02); exp_q.push_back(8'h57);
      start_frame(4'd5, 4'd5, 1'b1, sol_all);
      wait_done(200);
      valid_in = 1'b1;
      base = sends;
      cycle();
      valid_in = 1'b0;
      repeat (5) cycle();
      chk("t3_no_send_after_done_vin", sends - base, 0);
      chk("t3_busy_idle", busy, 0);

      // T4: stall transmit_done for 1000 cycles after SYNC
      auto_en = 1'b0;
      td_delay = 1;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h18); exp_q.push_back(8'h01);
      exp_q.push_back(8'hFF); exp_q.push_back(8'hE6);
      start_frame(4'd1, 4'd8, 1'b0, {{(MR*MC-8){1'b0}}, 8'hFF});
      extra = 0; unstable = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle();
         if (send) extra++;
         if (byte_out !== 8'hA5) unstable++;
      end
      chk("t4_stall_sends", extra, 0);
      chk("t4_stall_unstable", unstable, 0);
      chk("t4_stall_busy", busy, 1);
      auto_en = 1'b1;
      transmit_done = 1'b1;
      trig_cyc = cyc;
      wait_done(200);

      // T5: reset during the third byte of a full frame, then a clean T1
      td_delay = 2;
      push_t2();
      base = sends;
      start_frame(4'd11, 4'd11, 1'b0, sol_all);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (sends - base >= 3) begin hit = 1'b1; break; end
         cycle();
      end
      chk("t5_third_byte_seen", hit, 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_send", send, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", done, 0);
      exp_q.delete();
      repeat (3) cycle();
      rst = 1'b0;
      base = sends;
      repeat (20) cycle();
      chk("t5_no_send_after_rst", sends - base, 0);
      push_t1();
      start_frame(4'd2, 4'd2, 1'b0, sol1);
      wait_done(200);

      // T6: spurious transmit_done in IDLE, second valid_in mid-frame
      transmit_done = 1'b1;
      base = sends;
      repeat (4) cycle();
      chk("t6_idle_td_no_send", sends - base, 0);
      chk("t6_idle_td_busy", busy, 0);
      td_delay = 2;
      push_t1();
      base = sends;
      start_frame(4'd2, 4'd2, 1'b0, sol1);
      for (int i = 0; i < 100 && (sends - base) < 2; i++) cycle();
      m = 4'd3; n = 4'd3; unsolvable = 1'b1; solution = sol_all; valid_in = 1'b1;
      cycle();
      valid_in = 1'b0;
      wait_done(200);

      // T7: oversize dims clamp to 11x11; single cell at (10,10)
      td_delay = 1;
      exp_q.push_back(8'hA5); exp_q.push_back(8'hBB); exp_q.push_back(8'h01);
      for (int i = 0; i < 20; i++) exp_q.push_back(8'h00);
      exp_q.push_back(8'h00); exp_q.push_back(8'h20); exp_q.push_back(8'h9A);
      begin
         logic [MR*MC-1:0] s7;
         s7 = '0; s7[120] = 1'b1;
         start_frame(4'd15, 4'd12, 1'b0, s7);
      end
      wait_done(300);

      // T8: m==0 drops ROWS, DIM reports as given
      exp_q.push_back(8'hA5); exp_q.push_back(8'h05);
      exp_q.push_back(8'h01); exp_q.push_back(8'h04);
      start_frame(4'd0, 4'd5, 1'b0, sol_all);
      wait_done(200);

      // T9: columns beyond n and rows beyond m must not leak into the frame
      exp_q.push_back(8'hA5); exp_q.push_back(8'h13); exp_q.push_back(8'h01);
      exp_q.push_back(8'hE0); exp_q.push_back(8'hF2);
      start_frame(4'd1, 4'd3, 1'b0, {{(MR*MC-22){1'b0}}, 22'h3FFFFF});
      wait_done(200);

      repeat (5) cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d want=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
